// File: rtl/reaction_timer.sv
// reaction_timer: millisecond count-up stopwatch for the reaction game.
// It measures the time from a start pulse to a stop pulse and saturates at
// MAX_MS, which ends the measurement as a timeout. The frozen result and a
// one-cycle result_valid strobe go to the score/display logic.
module reaction_timer #(
  parameter int MAX_MS      = 1023,
  parameter int CLKS_PER_MS = 50000,
  localparam int W          = $clog2(MAX_MS + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stop,
  input  logic         clear,
  output logic [W-1:0] elapsed_ms,
  output logic         running,
  output logic         result_valid,
  output logic         timeout
);

  // The prescaler needs at least one bit, even when one clock equals one ms.
  localparam int PW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;

  localparam logic [PW-1:0] PRESCALE_LAST = PW'(CLKS_PER_MS - 1);
  localparam logic [PW-1:0] PRESCALE_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] PRESCALE_ONE  = PW'(1);
  localparam logic [W-1:0]  MS_ZERO       = {W{1'b0}};
  localparam logic [W-1:0]  MS_ONE        = W'(1);
  localparam logic [W-1:0]  MS_MAX        = W'(MAX_MS);
  // The tick taken at this value is the one that saturates the count.
  localparam logic [W-1:0]  MS_LAST       = W'(MAX_MS - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t        state_r;
  logic [PW-1:0] prescale_r;
  logic          tick_s;

  // A millisecond ends on the last prescaler count.
  always_comb begin
    tick_s = (prescale_r == PRESCALE_LAST);
  end

  // Measurement FSM with registered outputs. Priority while running is
  // clear, then stop, then tick. Stop on a tick edge discards that tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      prescale_r   <= PRESCALE_ZERO;
      elapsed_ms   <= MS_ZERO;
      running      <= 1'b0;
      result_valid <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      // result_valid is a strobe. Only the ending edge raises it.
      result_valid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r    <= ST_RUNNING;
            prescale_r <= PRESCALE_ZERO;
            elapsed_ms <= MS_ZERO;
            timeout    <= 1'b0;
            running    <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUNNING: begin
          if (clear) begin
            state_r    <= ST_IDLE;
            prescale_r <= PRESCALE_ZERO;
            elapsed_ms <= MS_ZERO;
            running    <= 1'b0;
          end else if (stop) begin
            state_r      <= ST_DONE;
            running      <= 1'b0;
            result_valid <= 1'b1;
          end else if (tick_s) begin
            prescale_r <= PRESCALE_ZERO;
            if (elapsed_ms == MS_LAST) begin
              state_r      <= ST_DONE;
              elapsed_ms   <= MS_MAX;
              timeout      <= 1'b1;
              running      <= 1'b0;
              result_valid <= 1'b1;
            end else begin
              elapsed_ms <= elapsed_ms + MS_ONE;
            end
          end else begin
            prescale_r <= prescale_r + PRESCALE_ONE;
          end
        end
        ST_DONE: begin
          if (clear) begin
            state_r    <= ST_IDLE;
            elapsed_ms <= MS_ZERO;
            timeout    <= 1'b0;
          end else if (start) begin
            state_r    <= ST_RUNNING;
            prescale_r <= PRESCALE_ZERO;
            elapsed_ms <= MS_ZERO;
            timeout    <= 1'b0;
            running    <= 1'b1;
          end else begin
            state_r <= ST_DONE;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          prescale_r <= PRESCALE_ZERO;
          elapsed_ms <= MS_ZERO;
          running    <= 1'b0;
          timeout    <= 1'b0;
        end
      endcase
    end
  end

endmodule
